img_sram_port: RTL and testbench

- Downstream stage of the UART image loader: accepts assembled 16-bit pixel writes (20-bit address, 16-bit data) and commits them to the DE2-115 IS61WV102416 SRAM.
- Also serves a display read channel, which has absolute priority over writes.
- An 8-entry write FIFO absorbs bursts while reads hold the bus; a frame counter reports when a full image has been committed.

---
 rtl/img_pkg.sv | 21 ++
 rtl/img_sram_port_wr_fifo.sv | 59 +++++
 rtl/img_sram_port.sv | 172 +++++++++++++++++
 tb/tb_img_sram_port.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared types for the image loader SRAM path: frame geometry defaults,
// the per-cycle SRAM bus operation and the pixel write payload.
package img_pkg;

  localparam int unsigned IMG_HEIGHT   = 480;
  localparam int unsigned IMG_WIDTH    = 800;
  localparam int unsigned FRAME_PIXELS = IMG_HEIGHT * IMG_WIDTH;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_TURN  = 2'd3
  } bus_op_e;

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
  } pixel_t;

endpackage

// File: rtl/img_sram_port_wr_fifo.sv
// Synchronous write FIFO with extra-MSB pointers; clr_i flushes the contents
// but still accepts a push arriving in the same cycle.
module wr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 36
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          wr_en;
  logic [AW-1:0] waddr;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot a full-FIFO push lands in.
  assign wr_en = push_i && (clr_i || !full_o || pop_i);
  assign waddr = clr_i ? '0 : wptr_q[AW-1:0];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr_i) begin
      rptr_d = '0;
      wptr_d = {{AW{1'b0}}, wr_en};
    end else begin
      wptr_d = wptr_q + {{AW{1'b0}}, wr_en};
      rptr_d = rptr_q + {{AW{1'b0}}, (pop_i && !empty_o)};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[waddr] <= din_i;
  end

endmodule

// File: rtl/img_sram_port.sv
// SRAM port for the image loader: buffered pixel writes, priority display reads.
// Define SRAM_PORT_STATS_EN to add the o_drop_cnt dropped-write counter.
module img_sram_port
  import img_pkg::*;
#(
  parameter int unsigned HEIGHT     = IMG_HEIGHT,
  parameter int unsigned WIDTH      = IMG_WIDTH,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic        i_start,
  input  logic        i_wr_valid,
  input  logic [19:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  input  logic        i_rd_req,
  input  logic [19:0] i_rd_addr,
  output logic        o_rd_valid,
  output logic [15:0] o_rd_data,
  output logic        o_overflow,
  output logic        o_frame_done,
  output logic [19:0] o_SRAM_ADDR,
  inout  wire  [15:0] io_SRAM_DQ,
  output logic        o_SRAM_CE_N,
  output logic        o_SRAM_OE_N,
  output logic        o_SRAM_WE_N,
  output logic        o_SRAM_LB_N,
  output logic        o_SRAM_UB_N,
`ifdef SRAM_PORT_STATS_EN
  output logic [15:0] o_drop_cnt,
`endif
  output logic [1:0]  o_dbg_op
);

  localparam logic [18:0] FRAME_LAST = 19'(HEIGHT * WIDTH - 1);

  bus_op_e     op_q, op_d;
  pixel_t      head, wr_pix;
  logic        fifo_empty, fifo_full, fifo_avail, pop, drop;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, be_n_q, be_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic [19:0] addr_q, addr_d;
  logic        rd_valid_q;
  logic [15:0] rd_data_q;
  logic        overflow_q, frame_done_q;
  logic [18:0] frame_cnt_q;

  assign wr_pix = '{addr: i_wr_addr, data: i_wr_data};

  wr_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(pixel_t))) u_fifo (
    .clk_i   (avm_clk),
    .rst_i   (avm_rst),
    .clr_i   (i_start),
    .push_i  (i_wr_valid),
    .din_i   (wr_pix),
    .pop_i   (pop),
    .dout_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Reads always win; a write right after a read waits one TURN cycle so the
  // SRAM has released DQ. i_start hides the FIFO so no flushed entry launches.
  always_comb begin
    op_d       = OP_IDLE;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    be_n_d     = 1'b1;
    dq_oe_d    = 1'b0;
    dq_out_d   = dq_out_q;
    addr_d     = addr_q;
    fifo_avail = !fifo_empty && !i_start;
    if (i_rd_req)        op_d = OP_READ;
    else if (fifo_avail) op_d = (op_q == OP_READ) ? OP_TURN : OP_WRITE;
    case (op_d)
      OP_READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = 1'b0;
        addr_d = i_rd_addr;
      end
      OP_WRITE: begin
        ce_n_d   = 1'b0;
        we_n_d   = 1'b0;
        be_n_d   = 1'b0;
        addr_d   = head.addr;
        dq_oe_d  = 1'b1;
        dq_out_d = head.data;
      end
      default: ;
    endcase
  end

  assign pop  = (op_d == OP_WRITE);
  assign drop = i_wr_valid && fifo_full && !pop && !i_start;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      op_q     <= OP_IDLE;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      be_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
      addr_q   <= '0;
    end else begin
      op_q     <= op_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      be_n_q   <= be_n_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
      addr_q   <= addr_d;
    end
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      rd_valid_q <= (op_q == OP_READ);
      if (op_q == OP_READ) rd_data_q <= io_SRAM_DQ;
      if (i_start)   overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;
      frame_done_q <= 1'b0;
      if (i_start) begin
        frame_cnt_q <= '0;
      end else if (op_q == OP_WRITE) begin
        if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_q  <= '0;
          frame_done_q <= 1'b1;
        end else begin
          frame_cnt_q <= frame_cnt_q + 19'd1;
        end
      end
    end
  end

`ifdef SRAM_PORT_STATS_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst)                              drop_cnt_q <= '0;
    else if (i_start)                         drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF)  drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

  assign io_SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign o_SRAM_ADDR  = addr_q;
  assign o_SRAM_CE_N  = ce_n_q;
  assign o_SRAM_OE_N  = oe_n_q;
  assign o_SRAM_WE_N  = we_n_q;
  assign o_SRAM_LB_N  = be_n_q;
  assign o_SRAM_UB_N  = be_n_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_data    = rd_data_q;
  assign o_overflow   = overflow_q;
  assign o_frame_done = frame_done_q;
  assign o_dbg_op     = op_q;

endmodule

// File: tb/tb_img_sram_port.sv
// Directed bench for img_sram_port with an SRAM model, write/read scoreboards
// and a frame-counter model; small 2x3 frame so frame_done is reachable.
module tb_img_sram_port;
  import img_pkg::*;

  localparam int H  = 2;
  localparam int W  = 3;
  localparam int FR = H * W;

  logic        avm_clk = 1'b0;
  logic        avm_rst;
  logic        i_start, i_wr_valid, i_rd_req;
  logic [19:0] i_wr_addr, i_rd_addr;
  logic [15:0] i_wr_data;
  logic        o_rd_valid, o_overflow, o_frame_done;
  logic [15:0] o_rd_data;
  logic [19:0] o_SRAM_ADDR;
  wire  [15:0] io_SRAM_DQ;
  logic        o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N;
  logic [1:0]  o_dbg_op;
`ifdef SRAM_PORT_STATS_EN
  logic [15:0] o_drop_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 avm_clk = ~avm_clk;
  always @(posedge avm_clk) cyc <= cyc + 1;

  img_sram_port #(.HEIGHT(H), .WIDTH(W), .FIFO_DEPTH(8)) dut (
    .avm_clk      (avm_clk),
    .avm_rst      (avm_rst),
    .i_start      (i_start),
    .i_wr_valid   (i_wr_valid),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_rd_req     (i_rd_req),
    .i_rd_addr    (i_rd_addr),
    .o_rd_valid   (o_rd_valid),
    .o_rd_data    (o_rd_data),
    .o_overflow   (o_overflow),
    .o_frame_done (o_frame_done),
    .o_SRAM_ADDR  (o_SRAM_ADDR),
    .io_SRAM_DQ   (io_SRAM_DQ),
    .o_SRAM_CE_N  (o_SRAM_CE_N),
    .o_SRAM_OE_N  (o_SRAM_OE_N),
    .o_SRAM_WE_N  (o_SRAM_WE_N),
    .o_SRAM_LB_N  (o_SRAM_LB_N),
    .o_SRAM_UB_N  (o_SRAM_UB_N),
`ifdef SRAM_PORT_STATS_EN
    .o_drop_cnt   (o_drop_cnt),
`endif
    .o_dbg_op     (o_dbg_op)
  );

  // SRAM model: drives DQ on reads, stores on writes; idle bus floats high.
  logic [15:0] sram [0:63];
  logic        sram_oe;
  logic        pl_en;
  logic [5:0]  pl_addr;
  logic [15:0] pl_data;

  assign sram_oe    = !o_SRAM_CE_N && !o_SRAM_OE_N && o_SRAM_WE_N;
  assign io_SRAM_DQ = sram_oe ? sram[o_SRAM_ADDR[5:0]] : 16'hzzzz;
  for (genvar b = 0; b < 16; b++) begin : g_pu
    pullup (io_SRAM_DQ[b]);
  end

  always @(negedge avm_clk) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    else if (!o_SRAM_CE_N && !o_SRAM_WE_N) sram[o_SRAM_ADDR[5:0]] <= io_SRAM_DQ;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge avm_clk);
      #1;
    end
  endtask

  // Scoreboards and event logs, all filled mid-cycle.
  logic [35:0] wr_q [$];
  logic [15:0] rd_q [$];
  int we_log [$];
  int oe_log [$];
  int rdv_log [$];
  int fd_log [$];
  int turn_log [$];
  int   cnt_m  = 0;
  logic fd_exp = 1'b0;

  always @(negedge avm_clk) begin
    if (avm_rst) begin
      wr_q.delete();
      cnt_m  = 0;
      fd_exp = 1'b0;
    end else begin
      chk("frame_done", o_frame_done, fd_exp);
      fd_exp = 1'b0;
      if (o_frame_done) fd_log.push_back(cyc);
      if (!o_SRAM_OE_N) begin
        oe_log.push_back(cyc);
        chk("rd_pins", {o_SRAM_CE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N}, 4'b0100);
      end
      if (o_SRAM_CE_N && o_SRAM_OE_N && o_SRAM_WE_N && o_dbg_op == OP_TURN)
        turn_log.push_back(cyc);
      if (!o_SRAM_WE_N) begin
        we_log.push_back(cyc);
        chk("wr_pins", {o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N}, 4'b0100);
        chk("wr_pending", wr_q.size() != 0, 1'b1);
        if (wr_q.size() != 0) chk("wr_pixel", {o_SRAM_ADDR, io_SRAM_DQ}, wr_q.pop_front());
        cnt_m++;
        if (cnt_m == FR) begin
          cnt_m  = 0;
          fd_exp = 1'b1;
        end
      end
      if (i_start) begin
        cnt_m  = 0;
        fd_exp = 1'b0;
      end
      if (o_rd_valid) begin
        rdv_log.push_back(cyc);
        chk("rd_pending", rd_q.size() != 0, 1'b1);
        if (rd_q.size() != 0) chk("rd_data", o_rd_data, rd_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] t1_data [0:2] = '{16'h1234, 16'hABCD, 16'h0F0F};

  initial begin
    int   t0, w0, o0, r0, f0, tu0;
    logic seen;
    avm_rst = 1'b1; i_start = 1'b0; i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_rd_req = 1'b0; i_rd_addr = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    step(3);
    chk("rst_ctrl", {o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N}, 5'h1F);
    chk("rst_addr", o_SRAM_ADDR, 20'h0);
    chk("rst_dq", io_SRAM_DQ, 16'hFFFF);
    chk("rst_rd", {o_rd_valid, o_rd_data}, 17'h0);
    chk("rst_flags", {o_overflow, o_frame_done}, 2'b00);
    avm_rst = 1'b0;
    step(2);

    // Three writes, no reads.
    w0 = we_log.size(); t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      i_wr_valid = 1'b1; i_wr_addr = 20'(i); i_wr_data = t1_data[i];
      wr_q.push_back({20'(i), t1_data[i]});
      step();
    end
    i_wr_valid = 1'b0;
    step(6);
    chk("t1_we_count", we_log.size() - w0, 3);
    chk("t1_we_first", we_log[w0], t0 + 2);
    chk("t1_we_last", we_log[w0+2], t0 + 4);
    for (int i = 0; i < 3; i++) chk("t1_sram", sram[i], t1_data[i]);

    // Single read of a preloaded word, then back-to-back reads.
    pl_en = 1'b1; pl_addr = 6'd5; pl_data = 16'hBEEF;
    step();
    pl_en = 1'b0;
    o0 = oe_log.size(); r0 = rdv_log.size(); t0 = cyc;
    i_rd_req = 1'b1; i_rd_addr = 20'd5; rd_q.push_back(16'hBEEF);
    step();
    i_rd_req = 1'b0;
    step(4);
    chk("t2_oe_n", oe_log.size() - o0, 1);
    chk("t2_oe_cyc", oe_log[o0], t0 + 1);
    chk("t2_rdv_n", rdv_log.size() - r0, 1);
    chk("t2_rdv_cyc", rdv_log[r0], t0 + 2);
    r0 = rdv_log.size(); t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      i_rd_req = 1'b1; i_rd_addr = 20'(i); rd_q.push_back(t1_data[i]);
      step();
    end
    i_rd_req = 1'b0;
    step(4);
    chk("t2_b2b_n", rdv_log.size() - r0, 3);
    chk("t2_b2b_first", rdv_log[r0], t0 + 2);
    chk("t2_b2b_last", rdv_log[r0+2], t0 + 4);

    // Read burst starves ten writes: eight queue, two drop, then TURN + 8 WRITEs.
    w0 = we_log.size(); r0 = rdv_log.size(); tu0 = turn_log.size(); t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      i_rd_req = 1'b1; i_rd_addr = 20'd5; rd_q.push_back(16'hBEEF);
      i_wr_valid = (i < 10); i_wr_addr = 20'(16 + i); i_wr_data = 16'h5000 + 16'(i);
      if (i < 8) wr_q.push_back({i_wr_addr, i_wr_data});
      step();
      if (i == 7) chk("t3_ovf_before", o_overflow, 1'b0);
      if (i == 8) chk("t3_ovf_after", o_overflow, 1'b1);
    end
    i_rd_req = 1'b0; i_wr_valid = 1'b0;
    step(12);
    chk("t3_rdv_n", rdv_log.size() - r0, 20);
    chk("t3_last_oe", oe_log[oe_log.size()-1], t0 + 20);
    chk("t3_turn_n", turn_log.size() - tu0, 1);
    chk("t3_turn_cyc", turn_log[tu0], t0 + 21);
    chk("t3_we_n", we_log.size() - w0, 8);
    chk("t3_we_first", we_log[w0], t0 + 22);
    chk("t3_we_last", we_log[w0+7], t0 + 29);
    chk("t3_ovf_sticky", o_overflow, 1'b1);
`ifdef SRAM_PORT_STATS_EN
    chk("t3_drop_cnt", o_drop_cnt, 16'd2);
`endif

    // Four writes queued under reads, then i_start with a simultaneous write.
    w0 = we_log.size(); t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      i_rd_req = 1'b1; i_rd_addr = 20'd5; rd_q.push_back(16'hBEEF);
      i_wr_valid = (i < 4) || (i == 5); i_start = (i == 5);
      i_wr_addr = 20'(40 + i); i_wr_data = 16'hC000 + 16'(i);
      if (i == 5) wr_q.push_back({i_wr_addr, i_wr_data});
      step();
      if (i == 4) chk("t5_ovf_pre", o_overflow, 1'b1);
      if (i == 5) chk("t5_ovf_clr", o_overflow, 1'b0);
    end
    i_rd_req = 1'b0; i_wr_valid = 1'b0; i_start = 1'b0;
    step(10);
    chk("t5_we_n", we_log.size() - w0, 1);
    chk("t5_we_cyc", we_log[w0], t0 + 10);
`ifdef SRAM_PORT_STATS_EN
    chk("t5_drop_cnt", o_drop_cnt, 16'd0);
`endif
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step(2);

    // Frame counter: two full 2x3 frames.
    f0 = fd_log.size();
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < FR; i++) begin
        i_wr_valid = 1'b1; i_wr_addr = 20'(20 + i); i_wr_data = 16'hF000 + 16'(j * 8 + i);
        wr_q.push_back({i_wr_addr, i_wr_data});
        step();
      end
      i_wr_valid = 1'b0;
      step(5);
      chk("t4_fd_n", fd_log.size() - f0, j + 1);
      chk("t4_fd_cyc", fd_log[f0+j], we_log[we_log.size()-1] + 1);
    end

    // Asynchronous reset in the middle of a WRITE.
    for (int i = 0; i < 3; i++) begin
      i_wr_valid = 1'b1; i_wr_addr = 20'(60 + i); i_wr_data = 16'h6000 + 16'(i);
      wr_q.push_back({i_wr_addr, i_wr_data});
      step();
    end
    i_wr_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (!o_SRAM_WE_N) seen = 1'b1;
      else step();
    end
    chk("t6_we_seen", seen, 1'b1);
    avm_rst = 1'b1;
    #1;
    chk("t6_ctrl", {o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N}, 5'h1F);
    chk("t6_dq", io_SRAM_DQ, 16'hFFFF);
    chk("t6_addr", o_SRAM_ADDR, 20'h0);
    chk("t6_rd", {o_rd_valid, o_rd_data}, 17'h0);
    chk("t6_flags", {o_overflow, o_frame_done}, 2'b00);
    step(2);
    avm_rst = 1'b0;
    w0 = we_log.size();
    step(6);
    chk("t6_no_we", we_log.size() - w0, 0);

    chk("end_wr_q", wr_q.size(), 0);
    chk("end_rd_q", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
